// File: rtl/gshare_branch_predictor_2w.sv
// gshare_branch_predictor_2w
//   Dual-issue gshare direction predictor. It holds a table of saturating counters
//   indexed by the low PC bits XOR a speculative global history register (GHR).
//   Lookups are combinational and serve two decode slots plus one fetch-time PC.
//   The table is trained from the two Execute-stage branches. The GHR is repaired
//   from the history snapshot carried down the pipe on a mispredict. After reset,
//   a sequential sweep clears the table to weakly not-taken before ready rises.
//
// Ports
//   clk, reset                    clock, asynchronous active-high reset
//   ready                         table initialised, predictions valid
//   pc1, pc2, nextPC              decode-slot PCs and fetch PC
//   dec_br1, dec_br2              decode slot holds a branch (speculative GHR shift)
//   prediction1/2, instMemPred    predicted directions (1 = taken)
//   ghr_snap                      current speculative GHR
//   branch1/2, branch_taken1/2    Execute-slot resolved branches and directions
//   pcE1/2, ghrE1/2               Execute-slot PCs and GHR snapshots
//   mispredict1/2                 Execute-slot mispredict flags
//   perf_branches, perf_mispred   performance counters
//
// Build option
//   BPU_PERF_CNT_EN  When defined, this builds the 32-bit wrapping perf counters.
//                    Otherwise perf_* are tied to 0.
//
// FSM states
//   state | meaning
//   INIT  | sweeping the table, one entry per cycle, predictions forced to 0
//   RUN   | normal lookup, training and GHR tracking

module gshare_branch_predictor_2w #(
  parameter int PC_W  = 11,
  parameter int IDX_W = 5,
  parameter int GHR_W = 5,
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  output logic             ready,
  input  logic [PC_W-1:0]  pc1,
  input  logic [PC_W-1:0]  pc2,
  input  logic [PC_W-1:0]  nextPC,
  input  logic             dec_br1,
  input  logic             dec_br2,
  output logic             prediction1,
  output logic             prediction2,
  output logic             instMemPred,
  output logic [GHR_W-1:0] ghr_snap,
  input  logic             branch1,
  input  logic             branch2,
  input  logic             branch_taken1,
  input  logic             branch_taken2,
  input  logic [PC_W-1:0]  pcE1,
  input  logic [PC_W-1:0]  pcE2,
  input  logic [GHR_W-1:0] ghrE1,
  input  logic [GHR_W-1:0] ghrE2,
  input  logic             mispredict1,
  input  logic             mispredict2,
  output logic [31:0]      perf_branches,
  output logic [31:0]      perf_mispred
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   init_ptr;
  logic               init_we;
  logic [CTR_W-1:0]   tbl [ENTRIES];
  logic [GHR_W-1:0]   ghr, ghr_nxt;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= INIT;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (init_ptr == IDX_W'(ENTRIES - 1)) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  // Output logic.
  always_comb begin
    ready   = (state == RUN);
    init_we = (state == INIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        init_ptr <= '0;
    else if (init_we) init_ptr <= init_ptr + 1'b1;
  end

  // Lookup: all three ports read with the speculative GHR.
  logic [IDX_W-1:0] idx1, idx2, idx_f, idx_e1, idx_e2;
  assign idx1   = pc1[IDX_W-1:0]    ^ IDX_W'(ghr);
  assign idx2   = pc2[IDX_W-1:0]    ^ IDX_W'(ghr);
  assign idx_f  = nextPC[IDX_W-1:0] ^ IDX_W'(ghr);
  assign idx_e1 = pcE1[IDX_W-1:0]   ^ IDX_W'(ghrE1);
  assign idx_e2 = pcE2[IDX_W-1:0]   ^ IDX_W'(ghrE2);

  assign prediction1 = ready & tbl[idx1][CTR_W-1];
  assign prediction2 = ready & tbl[idx2][CTR_W-1];
  assign instMemPred = ready & tbl[idx_f][CTR_W-1];
  assign ghr_snap    = ghr;

  // A slot-1 mispredict means slot 2 is on the wrong path.
  logic kill2, upd1, upd2, repair2;
  assign kill2   = branch1 & mispredict1;
  assign upd1    = ready & branch1;
  assign upd2    = ready & branch2 & ~kill2;
  assign repair2 = branch2 & mispredict2;

  logic signed [2:0] d1, d2;
  assign d1 = branch_taken1 ? 3'sd1 : -3'sd1;
  assign d2 = branch_taken2 ? 3'sd1 : -3'sd1;

  // Two extra headroom bits catch both underflow and overflow of a +/-2 step.
  function automatic logic [CTR_W-1:0] sat_upd(input logic [CTR_W-1:0] c,
                                               input logic signed [2:0] d);
    logic signed [CTR_W+1:0] s;
    s = $signed({2'b00, c}) + (CTR_W+2)'(d);
    if (s[CTR_W+1])  return '0;
    else if (s[CTR_W]) return '1;
    else             return s[CTR_W-1:0];
  endfunction

  // The table has no reset. The init sweep defines every entry before use.
  always_ff @(posedge clk) begin
    if (init_we) begin
      tbl[init_ptr] <= CTR_INIT;
    end else if (upd1 && upd2 && (idx_e1 == idx_e2)) begin
      tbl[idx_e1] <= sat_upd(tbl[idx_e1], d1 + d2);
    end else begin
      if (upd1) tbl[idx_e1] <= sat_upd(tbl[idx_e1], d1);
      if (upd2) tbl[idx_e2] <= sat_upd(tbl[idx_e2], d2);
    end
  end

  // Wide concatenations keep the shifts legal for GHR_W = 1. The low bits are the new history.
  logic [GHR_W:0]   rep1, rep2, sh_p1, sh_p2;
  logic [GHR_W+1:0] sh_both;
  assign rep1    = {ghrE1, branch_taken1};
  assign rep2    = {ghrE2, branch_taken2};
  assign sh_p1   = {ghr, prediction1};
  assign sh_p2   = {ghr, prediction2};
  assign sh_both = {ghr, prediction1, prediction2};

  always_comb begin
    ghr_nxt = ghr;
    if (kill2)                 ghr_nxt = rep1[GHR_W-1:0];
    else if (repair2)          ghr_nxt = rep2[GHR_W-1:0];
    else if (dec_br1 && dec_br2) ghr_nxt = sh_both[GHR_W-1:0];
    else if (dec_br1)          ghr_nxt = sh_p1[GHR_W-1:0];
    else if (dec_br2)          ghr_nxt = sh_p2[GHR_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      ghr <= '0;
    else if (ready) ghr <= ghr_nxt;
  end

`ifdef BPU_PERF_CNT_EN
  logic [1:0] n_br, n_mp;
  assign n_br = {1'b0, upd1} + {1'b0, upd2};
  assign n_mp = {1'b0, upd1 & mispredict1} + {1'b0, upd2 & mispredict2};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_branches <= '0;
      perf_mispred  <= '0;
    end else begin
      perf_branches <= perf_branches + 32'(n_br);
      perf_mispred  <= perf_mispred + 32'(n_mp);
    end
  end
`else
  assign perf_branches = '0;
  assign perf_mispred  = '0;
`endif

  logic unused_bits;
  assign unused_bits = &{1'b0, pc1[PC_W-1:IDX_W], pc2[PC_W-1:IDX_W], nextPC[PC_W-1:IDX_W],
                         pcE1[PC_W-1:IDX_W], pcE2[PC_W-1:IDX_W], rep1[GHR_W], rep2[GHR_W],
                         sh_p1[GHR_W], sh_p2[GHR_W], sh_both[GHR_W+1:GHR_W]};

endmodule

// File: tb/tb_gshare_branch_predictor_2w.sv
module tb_gshare_branch_predictor_2w;

  localparam int PC_W = 11, IDX_W = 5, GHR_W = 5, CTR_W = 2, N = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic             ready, prediction1, prediction2, instMemPred;
  logic [PC_W-1:0]  pc1, pc2, nextPC, pcE1, pcE2;
  logic             dec_br1, dec_br2, branch1, branch2, branch_taken1, branch_taken2;
  logic             mispredict1, mispredict2;
  logic [GHR_W-1:0] ghr_snap, ghrE1, ghrE2;
  logic [31:0]      perf_branches, perf_mispred;

  gshare_branch_predictor_2w #(.PC_W(PC_W), .IDX_W(IDX_W), .GHR_W(GHR_W), .CTR_W(CTR_W)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .pc1(pc1), .pc2(pc2), .nextPC(nextPC), .dec_br1(dec_br1), .dec_br2(dec_br2),
    .prediction1(prediction1), .prediction2(prediction2), .instMemPred(instMemPred),
    .ghr_snap(ghr_snap), .branch1(branch1), .branch2(branch2),
    .branch_taken1(branch_taken1), .branch_taken2(branch_taken2),
    .pcE1(pcE1), .pcE2(pcE2), .ghrE1(ghrE1), .ghrE2(ghrE2),
    .mispredict1(mispredict1), .mispredict2(mispredict2),
    .perf_branches(perf_branches), .perf_mispred(perf_mispred)
  );

  int tests = 0, fails = 0;

  // Behavioural model: counter values as plain ints, history as an int.
  int tab [N];
  int ghr_m, init_cnt;
  bit ready_m;
  int unsigned pb_m, pm_m;

  function automatic int idx_of(input int pc, input int h);
    return (pc % N) ^ (h % N);
  endfunction

  function automatic int pred_m(input int pc);
    if (!ready_m) return 0;
    return (tab[idx_of(pc, ghr_m)] >= 2) ? 1 : 0;
  endfunction

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : (v > 3) ? 3 : v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    init_cnt = 0; ghr_m = 0; ready_m = 0; pb_m = 0; pm_m = 0;
  endtask

  task automatic compare_all();
    check("ready", ready, ready_m);
    check("prediction1", prediction1, pred_m(pc1));
    check("prediction2", prediction2, pred_m(pc2));
    check("instMemPred", instMemPred, pred_m(nextPC));
    check("ghr_snap", ghr_snap, ghr_m);
`ifdef BPU_PERF_CNT_EN
    check("perf_branches", perf_branches, pb_m);
    check("perf_mispred", perf_mispred, pm_m);
`else
    check("perf_branches", perf_branches, 0);
    check("perf_mispred", perf_mispred, 0);
`endif
  endtask

  // Effect of the coming clock edge on the model, computed from the current inputs.
  task automatic model_edge();
    int p1, p2, d1, d2, i1, i2;
    bit kill, u2;
    if (reset) begin model_reset(); return; end
    if (!ready_m) begin
      init_cnt++;
      if (init_cnt == N) begin
        ready_m = 1;
        for (int k = 0; k < N; k++) tab[k] = 1;
      end
      return;
    end
    p1 = pred_m(pc1); p2 = pred_m(pc2);
    kill = branch1 && mispredict1;
    u2 = branch2 && !kill;
    d1 = branch_taken1 ? 1 : -1;
    d2 = branch_taken2 ? 1 : -1;
    i1 = idx_of(pcE1, ghrE1);
    i2 = idx_of(pcE2, ghrE2);
    if (branch1 && u2 && i1 == i2) tab[i1] = clamp(tab[i1] + d1 + d2);
    else begin
      if (branch1) tab[i1] = clamp(tab[i1] + d1);
      if (u2)      tab[i2] = clamp(tab[i2] + d2);
    end
    pb_m += (branch1 ? 1 : 0) + (u2 ? 1 : 0);
    pm_m += (kill ? 1 : 0) + ((u2 && mispredict2) ? 1 : 0);
    if (kill)                           ghr_m = ((ghrE1 * 2) + branch_taken1) % N;
    else if (branch2 && mispredict2)    ghr_m = ((ghrE2 * 2) + branch_taken2) % N;
    else begin
      if (dec_br1) ghr_m = ((ghr_m * 2) + p1) % N;
      if (dec_br2) ghr_m = ((ghr_m * 2) + p2) % N;
    end
  endtask

  // Called at posedge+1 with inputs set; compares, advances the model, returns at next posedge+1.
  task automatic step();
    #1;
    compare_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc1 = '0; pc2 = '0; nextPC = '0; pcE1 = '0; pcE2 = '0; ghrE1 = '0; ghrE2 = '0;
    dec_br1 = 0; dec_br2 = 0; branch1 = 0; branch2 = 0;
    branch_taken1 = 0; branch_taken2 = 0; mispredict1 = 0; mispredict2 = 0;
  endtask

  task automatic wait_ready(input string name);
    int lowc = 0;
    for (int k = 0; k < 100; k++) begin
      if (ready) break;
      lowc++;
      step();
    end
    check(name, lowc, 32);
  endtask

  task automatic lookup1(input string name, input int idx, input int exp);
    pc1 = PC_W'(idx ^ ghr_m);
    #1 check(name, prediction1, exp);
    step();
  endtask

  initial begin
    idle_inputs();
    #2 reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    step(); step();
    reset = 1'b0;

    wait_ready("init_len");
    for (int k = 0; k < N; k++) begin
      pc1 = PC_W'(k);
      #1 check("init_pred", prediction1, 0);
      step();
    end

    branch1 = 1; pcE1 = 3; ghrE1 = 0; branch_taken1 = 1;
    step(); step();
    idle_inputs();
    lookup1("train_e3", 3, 1);

    pc1 = 3; pc2 = 4; dec_br1 = 1; dec_br2 = 1;
    step();
    idle_inputs();
    #1 check("ghr_shift2", ghr_snap, 5'b00010);
    step();

    branch1 = 1; mispredict1 = 1; pcE1 = 0; ghrE1 = 5'b10110; branch_taken1 = 1;
    dec_br1 = 1; pc1 = 3;
    branch2 = 1; mispredict2 = 1; pcE2 = 9; ghrE2 = 0; branch_taken2 = 1;
    step();
    idle_inputs();
    #1 check("ghr_repair", ghr_snap, 5'b01101);
    lookup1("slot2_suppressed", 9, 0);

    branch1 = 1; branch2 = 1; pcE1 = 7; pcE2 = 7; branch_taken1 = 1; branch_taken2 = 1;
    step();
    idle_inputs();
    lookup1("dual_inc", 7, 1);
    branch1 = 1; pcE1 = 7; branch_taken1 = 0;
    step();
    idle_inputs();
    lookup1("dual_inc_is_3", 7, 1);

    branch1 = 1; branch2 = 1; pcE1 = 8; pcE2 = 8; branch_taken1 = 1; branch_taken2 = 0;
    step();
    idle_inputs();
    lookup1("dual_net0", 8, 0);
    branch1 = 1; pcE1 = 8; branch_taken1 = 1;
    step();
    idle_inputs();
    lookup1("dual_net0_is_1", 8, 1);

    reset = 1'b1; model_reset();
    step();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) step();
    reset = 1'b1; model_reset();
    step();
    reset = 1'b0;
    wait_ready("reinit_len");
    #1 check("perf_zero_br", perf_branches, 0);
    check("perf_zero_mp", perf_mispred, 0);

    for (int i = 0; i < 3000; i++) begin
      pc1 = PC_W'($urandom); pc2 = PC_W'($urandom); nextPC = PC_W'($urandom);
      dec_br1 = ($urandom_range(0, 2) == 0);
      dec_br2 = ($urandom_range(0, 2) == 0);
      branch1 = $urandom_range(0, 1) != 0;
      branch2 = $urandom_range(0, 1) != 0;
      branch_taken1 = $urandom_range(0, 3) != 0;
      branch_taken2 = $urandom_range(0, 1) != 0;
      pcE1 = PC_W'($urandom_range(0, 15));
      pcE2 = ($urandom_range(0, 3) == 0) ? pcE1 : PC_W'($urandom_range(0, 15));
      ghrE1 = GHR_W'($urandom_range(0, 3));
      ghrE2 = ($urandom_range(0, 1) != 0) ? ghrE1 : GHR_W'($urandom);
      mispredict1 = ($urandom_range(0, 5) == 0);
      mispredict2 = ($urandom_range(0, 5) == 0);
      reset = (i == 1500);
      if (reset) model_reset();
      step();
      reset = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
